lcd_seq_rom: RTL and testbench

//  Registered ROM bank for the ILI9341 SPI display sequencer.

---
 rtl/ili9341_pkg.sv | 45 ++++
 rtl/color_data_rom.sv | 25 ++
 rtl/lcd_seq_rom.sv | 140 ++++++++++++++
 tb/tb_lcd_seq_rom.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared ILI9341 constants: command opcodes, D/C flag values, fill colours and
// post-command delay counts used by the sequencer ROM.
package ili9341_pkg;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam logic [7:0] NOP      = 8'h00;
  localparam logic [7:0] SWRESET  = 8'h01;
  localparam logic [7:0] SLPOUT   = 8'h11;
  localparam logic [7:0] NORON    = 8'h13;
  localparam logic [7:0] INVOFF   = 8'h20;
  localparam logic [7:0] GAMSET   = 8'h26;
  localparam logic [7:0] DISPOFF  = 8'h28;
  localparam logic [7:0] DISPON   = 8'h29;
  localparam logic [7:0] CASET    = 8'h2A;
  localparam logic [7:0] PASET    = 8'h2B;
  localparam logic [7:0] RAMWR    = 8'h2C;
  localparam logic [7:0] MADCTL   = 8'h36;
  localparam logic [7:0] IDMOFF   = 8'h38;
  localparam logic [7:0] PIXSET   = 8'h3A;
  localparam logic [7:0] FRMCTR1  = 8'hB1;
  localparam logic [7:0] DFUNCTR  = 8'hB6;
  localparam logic [7:0] PWCTR1   = 8'hC0;
  localparam logic [7:0] PWCTR2   = 8'hC1;
  localparam logic [7:0] VMCTR1   = 8'hC5;
  localparam logic [7:0] VMCTR2   = 8'hC7;
  localparam logic [7:0] PWCTRB   = 8'hCF;
  localparam logic [7:0] ENABLE3G = 8'hF2;

  localparam logic [15:0] COLOR_RED = 16'hF800;

  localparam int DELAY_SWRESET = 5_000_000;
  localparam int DELAY_SLPOUT  = 5_000_000;
  localparam int DELAY_DISPON  = 1_000_000;

  function automatic logic [8:0] cmd_word(input logic [7:0] op);
    return {DC_CMD, op};
  endfunction

  function automatic logic [8:0] dat_word(input logic [7:0] b);
    return {DC_DATA, b};
  endfunction

endpackage

// File: rtl/color_data_rom.sv
// Pixel-byte source: maps a sequence address inside the pixel range to one byte
// of the RGB565 fill colour, high byte on odd addresses (the range starts at 47).
module color_data_rom
  import ili9341_pkg::*;
#(
  parameter int CMD_LIST_LENGTH  = 47,
  parameter int DATA_LIST_LENGTH = 153647,
  parameter int ADDR_W           = $clog2(DATA_LIST_LENGTH + 1)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       color,
  output logic [8:0]        data,
  output logic              in_range
);

  always_comb begin
    in_range = (addr >= ADDR_W'(CMD_LIST_LENGTH)) &&
               (addr <= ADDR_W'(DATA_LIST_LENGTH - 1));
    data = 9'h000;
    if (in_range) begin
      data = addr[0] ? {DC_DATA, color[15:8]} : {DC_DATA, color[7:0]};
    end
  end

endmodule

// File: rtl/lcd_seq_rom.sv
// Registered ROM bank for the ILI9341 SPI sequencer: init command table, then the
// fill-colour pixel stream, plus a per-entry post-transfer delay count.
module lcd_seq_rom
  import ili9341_pkg::*;
#(
  parameter int CMD_LIST_LENGTH  = 47,
  parameter int DATA_LIST_LENGTH = 153647,
  parameter int MAX_DELAY_COUNT  = 10_000_000,
  parameter int ADDR_W           = $clog2(DATA_LIST_LENGTH + 1),
  parameter int DELAY_W          = $clog2(MAX_DELAY_COUNT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [15:0]        color,
  output logic [8:0]         data,
  output logic [DELAY_W-1:0] delay
);

  localparam longint DELAY_LIMIT = longint'(1) << DELAY_W;

  // Refuse to elaborate if a delay constant cannot be represented or is out of bounds.
  generate
    if (DELAY_SWRESET >= MAX_DELAY_COUNT || DELAY_SLPOUT >= MAX_DELAY_COUNT ||
        DELAY_DISPON >= MAX_DELAY_COUNT  ||
        longint'(DELAY_SWRESET) >= DELAY_LIMIT ||
        longint'(DELAY_SLPOUT)  >= DELAY_LIMIT ||
        longint'(DELAY_DISPON)  >= DELAY_LIMIT) begin : g_bad_delay
      $error("lcd_seq_rom: delay constant does not fit DELAY_W / MAX_DELAY_COUNT");
    end
  endgenerate

  logic              cmd_sel;
  logic [8:0]        init_word;
  logic [DELAY_W-1:0] init_delay;
  logic [8:0]        pix_word;
  logic              pix_in_range;
  logic [8:0]        next_data;
  logic [DELAY_W-1:0] next_delay;

  color_data_rom #(
    .CMD_LIST_LENGTH (CMD_LIST_LENGTH),
    .DATA_LIST_LENGTH(DATA_LIST_LENGTH),
    .ADDR_W          (ADDR_W)
  ) u_color_data_rom (
    .addr    (addr),
    .color   (color),
    .data    (pix_word),
    .in_range(pix_in_range)
  );

  assign cmd_sel = (addr < ADDR_W'(CMD_LIST_LENGTH));

  always_comb begin
    init_word = 9'h000;
    case (addr[5:0])
      6'd0:  init_word = cmd_word(SWRESET);
      6'd1:  init_word = cmd_word(DISPOFF);
      6'd2:  init_word = cmd_word(PWCTRB);
      6'd3:  init_word = dat_word(8'h00);
      6'd4:  init_word = dat_word(8'hC1);
      6'd5:  init_word = dat_word(8'h30);
      6'd6:  init_word = cmd_word(PWCTR1);
      6'd7:  init_word = dat_word(8'h23);
      6'd8:  init_word = cmd_word(PWCTR2);
      6'd9:  init_word = dat_word(8'h10);
      6'd10: init_word = cmd_word(VMCTR1);
      6'd11: init_word = dat_word(8'h3E);
      6'd12: init_word = dat_word(8'h28);
      6'd13: init_word = cmd_word(VMCTR2);
      6'd14: init_word = dat_word(8'h86);
      6'd15: init_word = cmd_word(MADCTL);
      6'd16: init_word = dat_word(8'h48);
      6'd17: init_word = cmd_word(PIXSET);
      6'd18: init_word = dat_word(8'h55);
      6'd19: init_word = cmd_word(FRMCTR1);
      6'd20: init_word = dat_word(8'h00);
      6'd21: init_word = dat_word(8'h18);
      6'd22: init_word = cmd_word(DFUNCTR);
      6'd23: init_word = dat_word(8'h08);
      6'd24: init_word = dat_word(8'h82);
      6'd25: init_word = dat_word(8'h27);
      6'd26: init_word = cmd_word(SLPOUT);
      6'd27: init_word = cmd_word(DISPON);
      6'd28: init_word = cmd_word(CASET);
      6'd29: init_word = dat_word(8'h00);
      6'd30: init_word = dat_word(8'h00);
      6'd31: init_word = dat_word(8'h00);
      6'd32: init_word = dat_word(8'hEF);
      6'd33: init_word = cmd_word(PASET);
      6'd34: init_word = dat_word(8'h00);
      6'd35: init_word = dat_word(8'h00);
      6'd36: init_word = dat_word(8'h01);
      6'd37: init_word = dat_word(8'h3F);
      6'd38: init_word = cmd_word(GAMSET);
      6'd39: init_word = dat_word(8'h01);
      6'd40: init_word = cmd_word(ENABLE3G);
      6'd41: init_word = dat_word(8'h00);
      6'd42: init_word = cmd_word(NORON);
      6'd43: init_word = cmd_word(INVOFF);
      6'd44: init_word = cmd_word(IDMOFF);
      6'd45: init_word = cmd_word(NOP);
      6'd46: init_word = cmd_word(RAMWR);
      default: init_word = 9'h000;
    endcase
  end

  always_comb begin
    init_delay = '0;
    case (addr[5:0])
      6'd0:    init_delay = DELAY_W'(DELAY_SWRESET);
      6'd26:   init_delay = DELAY_W'(DELAY_SLPOUT);
      6'd27:   init_delay = DELAY_W'(DELAY_DISPON);
      default: init_delay = '0;
    endcase
  end

  // Beyond the last pixel the colour ROM already returns the idle word.
  always_comb begin
    next_data  = 9'h000;
    next_delay = '0;
    if (cmd_sel) begin
      next_data  = init_word;
      next_delay = init_delay;
    end else if (pix_in_range) begin
      next_data  = pix_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= 9'h000;
      delay <= '0;
    end else begin
      data  <= next_data;
      delay <= next_delay;
    end
  end

endmodule

// File: tb/tb_lcd_seq_rom.sv
// Self-checking bench for lcd_seq_rom: table/arithmetic reference model checked
// every cycle, plus directed literal checks at the interesting addresses.
module tb_lcd_seq_rom;

  localparam int CMD_LEN  = 47;
  localparam int DATA_LEN = 153647;
  localparam int AW       = 18;
  localparam int DW       = 24;

  logic          clk;
  logic          rst;
  logic [AW-1:0] addr;
  logic [15:0]   color;
  logic [8:0]    data;
  logic [DW-1:0] delay;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_seq_rom dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .color(color),
    .data (data),
    .delay(delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] init_tbl [0:46] = '{
    9'h001, 9'h028, 9'h0CF, 9'h100, 9'h1C1, 9'h130, 9'h0C0, 9'h123,
    9'h0C1, 9'h110, 9'h0C5, 9'h13E, 9'h128, 9'h0C7, 9'h186, 9'h036,
    9'h148, 9'h03A, 9'h155, 9'h0B1, 9'h100, 9'h118, 9'h0B6, 9'h108,
    9'h182, 9'h127, 9'h011, 9'h029, 9'h02A, 9'h100, 9'h100, 9'h100,
    9'h1EF, 9'h02B, 9'h100, 9'h100, 9'h101, 9'h13F, 9'h026, 9'h101,
    9'h0F2, 9'h100, 9'h013, 9'h020, 9'h038, 9'h000, 9'h02C
  };

  function automatic logic [8:0] model_data(input int a, input logic [15:0] c);
    if (a < CMD_LEN) return init_tbl[a];
    if (a < DATA_LEN) return (a % 2 == 1) ? {1'b1, c[15:8]} : {1'b1, c[7:0]};
    return 9'h000;
  endfunction

  function automatic int model_delay(input int a);
    if (a == 0)  return 5000000;
    if (a == 26) return 5000000;
    if (a == 27) return 1000000;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t addr=%0d)", name, act, exp, $time, addr);
    end
  endtask

  // Expected outputs: what the spec says appears after each edge.
  logic [8:0]  exp_data;
  int          exp_delay;
  logic        mdl_valid = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_data  <= 9'h000;
      exp_delay <= 0;
      mdl_valid <= 1'b1;
    end else begin
      exp_data  <= model_data(int'(addr), color);
      exp_delay <= model_delay(int'(addr));
      mdl_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("model_data", 32'(data), 32'(exp_data));
      chk("model_delay", 32'(delay), 32'(exp_delay));
    end
  end

  task automatic step(input int a, input logic [15:0] c);
    @(negedge clk);
    addr  = AW'(a);
    color = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    addr  = AW'(5);
    color = 16'h0000;
    #3;
    chk("reset_data_async", 32'(data), 32'h000);
    chk("reset_delay_async", 32'(delay), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_data_held", 32'(data), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_addr5", 32'(data), 32'h130);

    for (int i = 0; i < CMD_LEN; i++) begin
      step(i, 16'h0000);
      if (i == 0) begin
        chk("addr0_data", 32'(data), 32'h001);
        chk("addr0_delay", 32'(delay), 32'd5000000);
      end else if (i == 26) begin
        chk("addr26_delay", 32'(delay), 32'd5000000);
      end else if (i == 27) begin
        chk("addr27_data", 32'(data), 32'h029);
        chk("addr27_delay", 32'(delay), 32'd1000000);
      end else if (i == 46) begin
        chk("addr46_data", 32'(data), 32'h02C);
        chk("addr46_delay", 32'(delay), 32'd0);
      end
    end

    step(47, 16'hF800);
    chk("addr47_red", 32'(data), 32'h1F8);
    chk("addr47_delay", 32'(delay), 32'd0);
    step(48, 16'hF800);
    chk("addr48_red", 32'(data), 32'h100);
    chk("addr48_delay", 32'(delay), 32'd0);
    step(49, 16'hF800);
    chk("addr49_red", 32'(data), 32'h1F8);
    chk("addr49_delay", 32'(delay), 32'd0);

    step(1000, 16'h07E0);
    chk("addr1000_green", 32'(data), 32'h1E0);
    step(1001, 16'h07E0);
    chk("addr1001_green", 32'(data), 32'h107);

    // Colour change only affects reads from the edge it is sampled at onward.
    step(1002, 16'h1234);
    chk("color_change_lo", 32'(data), 32'h134);
    step(1003, 16'hABCD);
    chk("color_change_hi", 32'(data), 32'h1AB);

    step(DATA_LEN - 2, 16'hF800);
    chk("penultimate_pixel", 32'(data), 32'h1F8);
    step(DATA_LEN - 1, 16'hF800);
    chk("last_pixel", 32'(data), 32'h100);
    step(DATA_LEN, 16'hF800);
    chk("end_idle_data", 32'(data), 32'h000);
    chk("end_idle_delay", 32'(delay), 32'd0);
    step((1 << AW) - 1, 16'hF800);
    chk("max_addr_data", 32'(data), 32'h000);
    chk("max_addr_delay", 32'(delay), 32'd0);

    step(5000, 16'hF800);
    chk("addr5000_pre_rst", 32'(data), 32'h100);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_async", 32'(data), 32'h000);
    @(posedge clk);
    #1;
    chk("mid_rst_held", 32'(data), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("resume_5000", 32'(data), 32'h100);
    step(5001, 16'hF800);
    chk("resume_5001", 32'(data), 32'h1F8);

    for (int k = 0; k < 200; k++) begin
      step(int'($urandom_range(0, (1 << AW) - 1)), 16'($urandom));
    end
    for (int k = 0; k < 60; k++) begin
      step(int'($urandom_range(0, 60)), 16'($urandom));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
